// File: rtl/btn_conditioner.sv
// Button front end: 2-FF sync, debounce, press pulse, optional hold-to-repeat.
// Ports: clk, rst (sync, active-high), btn_raw[N_BTN] in; btn_pulse, btn_level out.
module btn_conditioner #(
  parameter int N_BTN         = 5,
  parameter int DEBOUNCE_CYC  = 500_000,
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 7_500_000,
  parameter logic [N_BTN-1:0] REPEAT_MASK = 5'b01111
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_pulse,
  output logic [N_BTN-1:0] btn_level
);

  localparam int DB_W = (DEBOUNCE_CYC > 1) ?
                        $clog2(DEBOUNCE_CYC) : 1;
  localparam int RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                          REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HD_W = (RP_MAX > 1) ? $clog2(RP_MAX) : 1;

  localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [HD_W-1:0] DLY_LAST = HD_W'(REPEAT_DELAY - 1);
  localparam logic [HD_W-1:0] PER_LAST = HD_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE,
    HELD_DELAY,
    HELD_REPEAT
  } rep_state_t;

  logic [N_BTN-1:0] sync1;
  logic [N_BTN-1:0] sync2;
  logic [N_BTN-1:0] lvl_nxt;
  logic [N_BTN-1:0] pulse_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    logic [DB_W-1:0] cnt_q;
    logic [DB_W-1:0] cnt_d;
    logic            lvl_d;
    logic [HD_W-1:0] hold_q;
    logic [HD_W-1:0] hold_d;
    rep_state_t      st_q;
    rep_state_t      st_d;
    logic            press;
    logic            fire;

    always_comb begin
      cnt_d = '0;
      lvl_d = btn_level[i];
      if (sync2[i] != btn_level[i]) begin
        if (cnt_q == DB_LAST) begin
          lvl_d = sync2[i];
        end else begin
          cnt_d = cnt_q + DB_W'(1);
        end
      end
    end

    assign press = lvl_d & ~btn_level[i];

    always_comb begin
      st_d   = st_q;
      hold_d = hold_q;
      fire   = 1'b0;
      if (!lvl_d) begin
        st_d   = IDLE;
        hold_d = '0;
      end else begin
        unique case (st_q)
          IDLE: begin
            if (press && REPEAT_MASK[i]) begin
              st_d   = HELD_DELAY;
              hold_d = '0;
            end
          end
          HELD_DELAY: begin
            if (hold_q == DLY_LAST) begin
              fire   = 1'b1;
              hold_d = '0;
              st_d   = HELD_REPEAT;
            end else begin
              hold_d = hold_q + HD_W'(1);
            end
          end
          HELD_REPEAT: begin
            if (hold_q == PER_LAST) begin
              fire   = 1'b1;
              hold_d = '0;
            end else begin
              hold_d = hold_q + HD_W'(1);
            end
          end
          default: begin
            st_d   = IDLE;
            hold_d = '0;
          end
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q  <= '0;
        hold_q <= '0;
        st_q   <= IDLE;
      end else begin
        cnt_q  <= cnt_d;
        hold_q <= hold_d;
        st_q   <= st_d;
      end
    end

    // A 1-cycle delay/period would otherwise strobe on back-to-back
    // cycles; suppress a repeat right after any pulse.
    assign lvl_nxt[i]   = lvl_d;
    assign pulse_nxt[i] = press | (fire & ~btn_pulse[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_level <= '0;
      btn_pulse <= '0;
    end else begin
      btn_level <= lvl_nxt;
      btn_pulse <= pulse_nxt;
    end
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner (debounce 4, delay 10, period 3).
// One task per scenario, inline checks, single summary line.
module tb_btn_conditioner;

  logic       clk;
  logic       rst;
  logic [4:0] btn_raw;
  logic [4:0] btn_pulse;
  logic [4:0] btn_level;

  int checks;
  int failures;

  int rep_at [11] = '{6, 16, 19, 22, 25, 28, 31, 34, 37, 40, 43};

  btn_conditioner #(
    .N_BTN        (5),
    .DEBOUNCE_CYC (4),
    .REPEAT_DELAY (10),
    .REPEAT_PERIOD(3),
    .REPEAT_MASK  (5'b01111)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (btn_raw),
    .btn_pulse(btn_pulse),
    .btn_level(btn_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit in_rep(int k);
    for (int j = 0; j < 11; j++)
      if (rep_at[j] == k) return 1'b1;
    return 1'b0;
  endfunction

  task automatic do_reset();
    btn_raw = '0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    btn_raw = 5'b11111;
    rst = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      step();
      checks++;
      if (btn_pulse !== 5'b0 || btn_level !== 5'b0) begin
        failures++;
        $display("FAIL reset k=%0d pulse=%b level=%b required 00000/00000",
                 k, btn_pulse, btn_level);
      end
    end
    btn_raw = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_clean_press();
    logic [4:0] ep, el;
    do_reset();
    for (int k = 1; k <= 18; k++) begin
      btn_raw[0] = (k <= 9);
      step();
      ep = (k == 6) ? 5'b00001 : 5'b0;
      el = (k >= 6 && k < 15) ? 5'b00001 : 5'b0;
      checks++;
      if (btn_pulse !== ep || btn_level !== el) begin
        failures++;
        $display("FAIL clean_press k=%0d pulse=%b level=%b required %b/%b",
                 k, btn_pulse, btn_level, ep, el);
      end
    end
  endtask

  task automatic test_bounce();
    logic [4:0] ep, el;
    do_reset();
    for (int k = 1; k <= 30; k++) begin
      if (k == 1 || k == 5 || k == 9 || k == 13) btn_raw[1] = 1'b1;
      if (k == 3 || k == 7 || k == 11 || k == 21) btn_raw[1] = 1'b0;
      step();
      ep = (k == 18) ? 5'b00010 : 5'b0;
      el = (k >= 18 && k < 26) ? 5'b00010 : 5'b0;
      checks++;
      if (btn_pulse !== ep || btn_level !== el) begin
        failures++;
        $display("FAIL bounce k=%0d pulse=%b level=%b required %b/%b",
                 k, btn_pulse, btn_level, ep, el);
      end
    end
  endtask

  task automatic test_glitch();
    logic [4:0] ep, el;
    do_reset();
    for (int k = 1; k <= 15; k++) begin
      btn_raw[2] = !(k >= 7 && k <= 9);
      step();
      ep = (k == 6) ? 5'b00100 : 5'b0;
      el = (k >= 6) ? 5'b00100 : 5'b0;
      checks++;
      if (btn_pulse !== ep || btn_level !== el) begin
        failures++;
        $display("FAIL glitch k=%0d pulse=%b level=%b required %b/%b",
                 k, btn_pulse, btn_level, ep, el);
      end
    end
  endtask

  task automatic test_repeat();
    logic [4:0] ep, el;
    do_reset();
    for (int k = 1; k <= 55; k++) begin
      btn_raw[0] = (k <= 40);
      step();
      ep = in_rep(k) ? 5'b00001 : 5'b0;
      el = (k >= 6 && k < 46) ? 5'b00001 : 5'b0;
      checks++;
      if (btn_pulse !== ep || btn_level !== el) begin
        failures++;
        $display("FAIL repeat k=%0d pulse=%b level=%b required %b/%b",
                 k, btn_pulse, btn_level, ep, el);
      end
    end
  endtask

  task automatic test_no_repeat_simul();
    logic [4:0] ep, el;
    do_reset();
    for (int k = 1; k <= 55; k++) begin
      btn_raw[4] = (k <= 40);
      btn_raw[3] = (k <= 40);
      step();
      ep = (in_rep(k) ? 5'b01000 : 5'b0) |
           ((k == 6) ? 5'b10000 : 5'b0);
      el = (k >= 6 && k < 46) ? 5'b11000 : 5'b0;
      checks++;
      if (btn_pulse !== ep || btn_level !== el) begin
        failures++;
        $display("FAIL no_repeat k=%0d pulse=%b level=%b required %b/%b",
                 k, btn_pulse, btn_level, ep, el);
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    logic [4:0] ep, el;
    do_reset();
    btn_raw[0] = 1'b1;
    for (int k = 1; k <= 34; k++) begin
      rst = (k == 21 || k == 22);
      step();
      if (k <= 20) begin
        ep = (k == 6 || k == 16 || k == 19) ? 5'b00001 : 5'b0;
        el = (k >= 6) ? 5'b00001 : 5'b0;
      end else if (k <= 22) begin
        ep = 5'b0;
        el = 5'b0;
      end else begin
        ep = (k == 28) ? 5'b00001 : 5'b0;
        el = (k >= 28) ? 5'b00001 : 5'b0;
      end
      checks++;
      if (btn_pulse !== ep || btn_level !== el) begin
        failures++;
        $display("FAIL reset_mid k=%0d pulse=%b level=%b required %b/%b",
                 k, btn_pulse, btn_level, ep, el);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    btn_raw  = '0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_repeat();
    test_no_repeat_simul();
    test_reset_mid_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
